// File: rtl/sm_pkg.sv
// Shared types and default widths for the sign-magnitude accumulator.
package sm_pkg;

    localparam int SM_N_DEF     = 4;
    localparam int SM_ACC_W_DEF = 8;
    localparam int SM_COUNT_DEF = 4;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } sm_state_e;

    // Counter must be able to hold COUNT itself.
    function automatic int sm_cnt_w(input int count);
        return (count < 2) ? 1 : $clog2(count + 1);
    endfunction

endpackage

// File: rtl/sm_addsub_w.sv
// Combinational sign-magnitude add/subtract of two W-bit magnitudes.
// carry is only ever set by a same-sign add that exceeds W bits.
module sm_addsub_w #(
    parameter int W = 7
) (
    input  logic         a_sign,
    input  logic [W-1:0] a_mag,
    input  logic         b_sign,
    input  logic [W-1:0] b_mag,
    output logic         r_sign,
    output logic [W-1:0] r_mag,
    output logic         carry
);

    always_comb begin
        r_sign = a_sign;
        r_mag  = '0;
        carry  = 1'b0;
        if (a_sign == b_sign) begin
            {carry, r_mag} = {1'b0, a_mag} + {1'b0, b_mag};
        end else if (b_mag > a_mag) begin
            r_mag  = b_mag - a_mag;
            r_sign = b_sign;
        end else begin
            // Equal magnitudes land here and keep the accumulator sign.
            r_mag = a_mag - b_mag;
        end
    end

endmodule

// File: rtl/sm_accumulator.sv
// Sign-magnitude block accumulator: sums COUNT samples, then presents the result.
// Define SM_ACC_SAT_EN to saturate on overflow instead of wrapping.
module sm_accumulator
    import sm_pkg::*;
#(
    parameter int N     = SM_N_DEF,
    parameter int ACC_W = SM_ACC_W_DEF,
    parameter int COUNT = SM_COUNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             out_ready
);

    localparam int M  = ACC_W - 1;
    localparam int CW = sm_cnt_w(COUNT);

    sm_state_e    state_q, state_d;
    logic         acc_sign_q, acc_sign_d;
    logic [M-1:0] acc_mag_q, acc_mag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    logic         in_sign;
    logic [M-1:0] in_mag;
    logic         sum_sign, sum_carry;
    logic [M-1:0] sum_mag;
    logic         nxt_sign;
    logic [M-1:0] nxt_mag;
    logic         accept, release_blk;

    assign in_sign = in_data[N-1];
    assign in_mag  = {{(M-N+1){1'b0}}, in_data[N-2:0]};

    sm_addsub_w #(.W(M)) u_addsub (
        .a_sign (acc_sign_q),
        .a_mag  (acc_mag_q),
        .b_sign (in_sign),
        .b_mag  (in_mag),
        .r_sign (sum_sign),
        .r_mag  (sum_mag),
        .carry  (sum_carry)
    );

    always_comb begin
        nxt_sign = sum_sign;
        nxt_mag  = sum_mag;
`ifdef SM_ACC_SAT_EN
        if (sum_carry) nxt_mag = '1;
`endif
        // A wrapped or cancelled result must never leave a negative zero.
        if (nxt_mag == '0) nxt_sign = 1'b0;
    end

    assign accept      = (state_q == ACC) && in_valid;
    assign release_blk = (state_q == OUT) && out_ready;

    always_comb begin
        state_d    = state_q;
        acc_sign_d = acc_sign_q;
        acc_mag_d  = acc_mag_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (clr || release_blk) begin
            state_d    = ACC;
            acc_sign_d = 1'b0;
            acc_mag_d  = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
        end else if (accept) begin
            acc_sign_d = nxt_sign;
            acc_mag_d  = nxt_mag;
            cnt_d      = cnt_q + CW'(1);
            ovf_d      = ovf_q | sum_carry;
            if (cnt_q == CW'(COUNT - 1)) state_d = OUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            acc_sign_q <= 1'b0;
            acc_mag_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_sign_q <= acc_sign_d;
            acc_mag_q  <= acc_mag_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign out_data  = {acc_sign_q, acc_mag_q};
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Bench for sm_accumulator: default instance plus a narrow ACC_W=5 instance for overflow.
module tb_sm_accumulator;

    logic       clk = 1'b0;
    logic       rst, clr;
    logic       sel;
    logic       drv_valid, drv_ordy;
    logic [3:0] drv_data;

    logic       in_valid, in_ready, out_valid, out_ovf, out_ready;
    logic [7:0] out_data;
    logic       in_valid5, in_ready5, out_valid5, out_ovf5, out_ready5;
    logic [4:0] out_data5;

    logic       c_in_ready, c_out_valid, c_out_ovf;
    logic [7:0] c_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic m_sign, m_ovf;
    int   m_mag;

    always #5 clk = ~clk;

    assign in_valid   = !sel && drv_valid;
    assign in_valid5  = sel && drv_valid;
    assign out_ready  = !sel && drv_ordy;
    assign out_ready5 = sel && drv_ordy;

    assign c_in_ready  = sel ? in_ready5  : in_ready;
    assign c_out_valid = sel ? out_valid5 : out_valid;
    assign c_out_ovf   = sel ? out_ovf5   : out_ovf;
    assign c_out_data  = sel ? {3'b000, out_data5} : out_data;

    sm_accumulator dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(drv_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
        .out_ready(out_ready)
    );

    sm_accumulator #(.N(4), .ACC_W(5), .COUNT(4)) dut5 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid5), .in_data(drv_data), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_ovf(out_ovf5),
        .out_ready(out_ready5)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: signed-magnitude arithmetic straight from the rules, on plain ints.
    task automatic model_clear;
        m_sign = 1'b0;
        m_mag  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_acc(input logic [3:0] d, input int accw);
        int mx;
        int im;
        mx = (1 << (accw - 1)) - 1;
        im = int'(d[2:0]);
        if (d[3] == m_sign) begin
            m_mag = m_mag + im;
            if (m_mag > mx) begin
                m_ovf = 1'b1;
`ifdef SM_ACC_SAT_EN
                m_mag = mx;
`else
                m_mag = m_mag % (mx + 1);
`endif
            end
        end else if (im > m_mag) begin
            m_mag  = im - m_mag;
            m_sign = d[3];
        end else begin
            m_mag = m_mag - im;
        end
        if (m_mag == 0) m_sign = 1'b0;
    endtask

    function automatic logic [7:0] model_out(input int accw);
        int v;
        v = (int'(m_sign) << (accw - 1)) | m_mag;
        return v[7:0];
    endfunction

    task automatic send(input logic [3:0] d);
        int t;
        t = 0;
        drv_valid = 1'b1;
        drv_data  = d;
        while (!c_in_ready && t < 20) begin
            step;
            t++;
        end
        n_cmp++;
        if (c_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_wait in_ready=%b required 1", c_in_ready);
        end
        step;
        drv_valid = 1'b0;
    endtask

    task automatic release_blk;
        drv_ordy = 1'b1;
        step;
        drv_ordy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            n_cmp++;
            if ({c_out_valid, c_in_ready, c_out_ovf, c_out_data} !== {3'b010, 8'h00}) begin
                n_bad++;
                $display("FAIL reset_state sel=%0d v/r/o/d=%b%b%b %h required 0100 00",
                         s, c_out_valid, c_in_ready, c_out_ovf, c_out_data);
            end
        end
        rst = 1'b0;
        sel = 1'b0;
    endtask

    task automatic run_block(input logic [15:0] samples, input logic [7:0] exp_d,
                             input logic exp_o, input int accw, input string name);
        logic [3:0] s;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            s = samples[15-4*k -: 4];
            send(s);
            model_acc(s, accw);
            n_cmp++;
            if (c_out_valid !== (k == 3)) begin
                n_bad++;
                $display("FAIL %s_valid_timing k=%0d out_valid=%b required %b",
                         name, k, c_out_valid, (k == 3));
            end
        end
        n_cmp++;
        if (c_out_data !== exp_d || c_out_ovf !== exp_o || c_out_data !== model_out(accw)) begin
            n_bad++;
            $display("FAIL %s_result data=%h ovf=%b required data=%h ovf=%b (model %h)",
                     name, c_out_data, c_out_ovf, exp_d, exp_o, model_out(accw));
        end
        release_blk();
    endtask

    task automatic test_sums;
        sel = 1'b0;
        run_block(16'h3294, 8'h08, 1'b0, 8, "sum_mixed");
        run_block(16'h5D08, 8'h00, 1'b0, 8, "sum_cancel");
    endtask

    task automatic test_overflow;
        sel = 1'b1;
`ifdef SM_ACC_SAT_EN
        run_block(16'h7777, 8'h0F, 1'b1, 5, "ovf_sat");
`else
        run_block(16'h7777, 8'h0C, 1'b1, 5, "ovf_wrap");
`endif
        sel = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [7:0] held;
        sel = 1'b0;
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        held = c_out_data;
        n_cmp++;
        if (held !== 8'h0A) begin
            n_bad++;
            $display("FAIL bp_result data=%h required 0a", held);
        end
        drv_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drv_data = 4'($urandom_range(0, 15));
            step;
            n_cmp++;
            if (c_out_data !== held || c_in_ready !== 1'b0 || c_out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold c=%0d data=%h in_ready=%b out_valid=%b required %h 0 1",
                         c, c_out_data, c_in_ready, c_out_valid, held);
            end
        end
        release_blk();
        drv_valid = 1'b0;
        n_cmp++;
        if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0 || c_out_data !== 8'h00) begin
            n_bad++;
            $display("FAIL bp_release in_ready=%b out_valid=%b data=%h required 1 0 00",
                     c_in_ready, c_out_valid, c_out_data);
        end
    endtask

    task automatic test_clr;
        sel = 1'b0;
        send(4'h5); send(4'h6);
        clr = 1'b1;
        drv_valid = 1'b1;
        drv_data  = 4'h7;
        step;
        clr = 1'b0;
        drv_valid = 1'b0;
        n_cmp++;
        if (c_out_data !== 8'h00 || c_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_abort data=%h in_ready=%b required 00 1", c_out_data, c_in_ready);
        end
        run_block(16'h9AB1, 8'h85, 1'b0, 8, "clr_after");
        send(4'h3);
        clr = 1'b1;
        rst = 1'b1;
        step;
        clr = 1'b0;
        rst = 1'b0;
        n_cmp++;
        if ({c_out_valid, c_in_ready, c_out_ovf, c_out_data} !== {3'b010, 8'h00}) begin
            n_bad++;
            $display("FAIL clr_rst v/r/o/d=%b%b%b %h required 0100 00",
                     c_out_valid, c_in_ready, c_out_ovf, c_out_data);
        end
    endtask

    task automatic test_rst_in_out;
        sel = 1'b1;
        send(4'h7); send(4'h7); send(4'h7); send(4'h7);
        n_cmp++;
        if (c_out_valid !== 1'b1 || c_out_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_out_pre out_valid=%b ovf=%b required 1 1", c_out_valid, c_out_ovf);
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        n_cmp++;
        if (c_out_valid !== 1'b0 || c_out_data !== 8'h00 || c_out_ovf !== 1'b0 || c_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_out_post out_valid=%b data=%h ovf=%b in_ready=%b required 0 00 0 1",
                     c_out_valid, c_out_data, c_out_ovf, c_in_ready);
        end
        sel = 1'b0;
    endtask

    task automatic test_random(input int blocks);
        logic [3:0] s;
        logic [7:0] held;
        int accw;
        for (int b = 0; b < blocks; b++) begin
            sel  = b[0];
            accw = sel ? 5 : 8;
            model_clear();
            for (int k = 0; k < 4; k++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) step;
                s = 4'($urandom_range(0, 15));
                send(s);
                model_acc(s, accw);
            end
            n_cmp++;
            if (c_out_valid !== 1'b1 || c_out_data !== model_out(accw) || c_out_ovf !== m_ovf) begin
                n_bad++;
                $display("FAIL rand_result blk=%0d valid=%b data=%h ovf=%b required 1 %h %b",
                         b, c_out_valid, c_out_data, c_out_ovf, model_out(accw), m_ovf);
            end
            held = c_out_data;
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                step;
                n_cmp++;
                if (c_out_data !== held || c_out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rand_hold blk=%0d data=%h valid=%b required %h 1",
                             b, c_out_data, c_out_valid, held);
                end
            end
            release_blk();
        end
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; sel = 1'b0;
        drv_valid = 1'b0; drv_ordy = 1'b0; drv_data = 4'h0;
        test_reset();
        test_sums();
        test_overflow();
        test_backpressure();
        test_clr();
        test_rst_in_out();
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
